// File: rtl/tmds_serializer.sv
// Three-lane TMDS bit serializer with a clock-lane pattern generator, running on the bit clock.
// A one-word hold register sits between the upstream valid/ready handshake and the lane shifters.
module tmds_serializer #(
    parameter logic [9:0] IDLE_SYM = 10'b1101010100,
    parameter logic [9:0] CLK_SYM  = 10'b0000011111,
    parameter int         UCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [9:0]        s_tmds0,
    input  logic [9:0]        s_tmds1,
    input  logic [9:0]        s_tmds2,
    output logic              data0_p,
    output logic              data1_p,
    output logic              data2_p,
    output logic              clk_p,
    output logic              word_start,
    output logic [UCNT_W-1:0] underflow_cnt
);

    logic              run_reg;
    logic [3:0]        bit_cnt_reg;
    logic              hold_full_reg;
    logic              armed_reg;
    logic              word_start_reg;
    logic [UCNT_W-1:0] ucnt_reg;
    logic [9:0]        clk_shift_reg;

    logic [2:0][9:0]   lane_in;
    logic [2:0]        lane_bit;
    logic              load;
    logic              accept;
    logic              underflow;

    assign lane_in   = {s_tmds2, s_tmds1, s_tmds0};
    assign load      = run_reg & (bit_cnt_reg == 4'd9);
    assign s_ready   = run_reg & (~hold_full_reg | load);
    assign accept    = s_valid & s_ready;
    assign underflow = load & ~hold_full_reg & armed_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg        <= 1'b0;
            bit_cnt_reg    <= 4'd9;
            hold_full_reg  <= 1'b0;
            armed_reg      <= 1'b0;
            word_start_reg <= 1'b0;
            ucnt_reg       <= '0;
        end else begin
            run_reg        <= 1'b1;
            word_start_reg <= load;
            if (run_reg) begin
                bit_cnt_reg <= (bit_cnt_reg == 4'd9) ? 4'd0 : bit_cnt_reg + 4'd1;
            end
            // A simultaneous accept refills the hold as the old word leaves it.
            if (accept) begin
                hold_full_reg <= 1'b1;
                armed_reg     <= 1'b1;
            end else if (load) begin
                hold_full_reg <= 1'b0;
            end
            if (underflow && (ucnt_reg != {UCNT_W{1'b1}})) begin
                ucnt_reg <= ucnt_reg + {{(UCNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_shift_reg <= '0;
        end else if (load) begin
            clk_shift_reg <= CLK_SYM;
        end else begin
            clk_shift_reg <= {1'b0, clk_shift_reg[9:1]};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [9:0] hold_reg;
            logic [9:0] shift_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg  <= '0;
                    shift_reg <= '0;
                end else begin
                    if (accept) begin
                        hold_reg <= lane_in[gi];
                    end
                    if (load) begin
                        shift_reg <= hold_full_reg ? hold_reg : IDLE_SYM;
                    end else begin
                        shift_reg <= {1'b0, shift_reg[9:1]};
                    end
                end
            end

            assign lane_bit[gi] = shift_reg[0];
        end
    endgenerate

    assign data0_p       = lane_bit[0];
    assign data1_p       = lane_bit[1];
    assign data2_p       = lane_bit[2];
    assign clk_p         = clk_shift_reg[0];
    assign word_start    = word_start_reg;
    assign underflow_cnt = ucnt_reg;

endmodule

// File: tb/tb_tmds_serializer.sv
// Directed bench for tmds_serializer: words are reassembled from the serial lanes and
// compared against hand-computed symbols; a 4-bit counter instance covers saturation.
module tb_tmds_serializer;

    localparam logic [9:0] IDLE = 10'b1101010100;
    localparam logic [9:0] CSYM = 10'b0000011111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic [9:0]  s_tmds0 = '0, s_tmds1 = '0, s_tmds2 = '0;
    logic        s_ready, data0_p, data1_p, data2_p, clk_p, word_start;
    logic [15:0] ucnt;
    logic        s_ready4, d0_4, d1_4, d2_4, clk_p4, ws4;
    logic [3:0]  ucnt4;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [9:0] q0[$], q1[$], q2[$];
    int acc_q[$];
    logic [9:0] gw0, gw1, gw2, gwc, gws, grdy;

    always #5 clk = ~clk;

    tmds_serializer dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_tmds0(s_tmds0), .s_tmds1(s_tmds1), .s_tmds2(s_tmds2),
        .data0_p(data0_p), .data1_p(data1_p), .data2_p(data2_p), .clk_p(clk_p),
        .word_start(word_start), .underflow_cnt(ucnt)
    );

    tmds_serializer #(.UCNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
        .s_tmds0(s_tmds0), .s_tmds1(s_tmds1), .s_tmds2(s_tmds2),
        .data0_p(d0_4), .data1_p(d1_4), .data2_p(d2_4), .clk_p(clk_p4),
        .word_start(ws4), .underflow_cnt(ucnt4)
    );

    task automatic drive();
        if (q0.size() > 0) begin
            s_valid = 1'b1;
            s_tmds0 = q0[0];
            s_tmds1 = q1[0];
            s_tmds2 = q2[0];
        end else begin
            s_valid = 1'b0;
            s_tmds0 = '0;
            s_tmds1 = '0;
            s_tmds2 = '0;
        end
    endtask

    // Advance one clock; inputs and outputs are handled 1 ns after the rising edge.
    task automatic step();
        logic acc;
        acc = s_valid & s_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            acc_q.push_back(cyc);
            void'(q0.pop_front());
            void'(q1.pop_front());
            void'(q2.pop_front());
        end
        drive();
    endtask

    task automatic push(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        q0.push_back(a);
        q1.push_back(b);
        q2.push_back(c);
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        acc_q.delete();
        drive();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for word_start, then gathers one 10-bit word from every lane.
    task automatic get_word();
        int n = 0;
        while (word_start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (word_start !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL word_start_timeout: word_start=%b after %0d cycles, required 1", word_start, n);
        end
        for (int k = 0; k < 10; k++) begin
            gw0[k]  = data0_p;
            gw1[k]  = data1_p;
            gw2[k]  = data2_p;
            gwc[k]  = clk_p;
            gws[k]  = word_start;
            grdy[k] = s_ready;
            step();
        end
        $display("word: lane0=%h lane1=%h lane2=%h clk=%h ws=%b ucnt=%0d", gw0, gw1, gw2, gwc, gws, ucnt);
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({data0_p, data1_p, data2_p, clk_p, word_start, s_ready} !== 6'b0 || ucnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_outputs: d/clk/ws/rdy=%b ucnt=%0d, required 000000 and 0",
                     {data0_p, data1_p, data2_p, clk_p, word_start, s_ready}, ucnt);
        end
        drive();
        step();
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (s_ready !== 1'b1 || word_start !== 1'b0) begin
            bad++;
            $display("FAIL run_after_release: s_ready=%b word_start=%b, required 1 0", s_ready, word_start);
        end
        step();
        total++;
        if (word_start !== 1'b1) begin
            bad++;
            $display("FAIL first_word_start: word_start=%b, required 1", word_start);
        end
        get_word();
        total++;
        if (gw0 !== IDLE || gw1 !== IDLE || gw2 !== IDLE) begin
            bad++;
            $display("FAIL t1_idle: lanes=%h/%h/%h, required %h", gw0, gw1, gw2, IDLE);
        end
        total++;
        if (gwc !== CSYM || gws !== 10'b0000000001) begin
            bad++;
            $display("FAIL t1_clk_ws: clk=%h ws=%b, required %h 0000000001", gwc, gws, CSYM);
        end
        get_word();
        total++;
        if (ucnt !== 16'd0) begin
            bad++;
            $display("FAIL t1_ucnt: underflow_cnt=%0d, required 0", ucnt);
        end
    endtask

    task automatic test_stream();
        do_reset();
        push(10'h3FF, 10'h011, 10'h022);
        push(10'h000, 10'h033, 10'h044);
        push(10'h155, 10'h055, 10'h066);
        get_word();
        total++;
        if (gw0 !== IDLE || grdy !== 10'b1000000000) begin
            bad++;
            $display("FAIL t2_lead_idle: lane0=%h rdy=%b, required %h 1000000000", gw0, grdy, IDLE);
        end
        get_word();
        total++;
        if (gw0 !== 10'h3FF || gw1 !== 10'h011 || grdy !== 10'b1000000000) begin
            bad++;
            $display("FAIL t2_word0: lane0=%h lane1=%h rdy=%b, required 3ff 011 1000000000", gw0, gw1, grdy);
        end
        get_word();
        total++;
        if (gw0 !== 10'h000 || gw2 !== 10'h044) begin
            bad++;
            $display("FAIL t2_word1: lane0=%h lane2=%h, required 000 044", gw0, gw2);
        end
        get_word();
        total++;
        if (gw0 !== 10'h155 || gw1 !== 10'h055 || grdy !== 10'h3FF) begin
            bad++;
            $display("FAIL t2_word2: lane0=%h lane1=%h rdy=%b, required 155 055 1111111111", gw0, gw1, grdy);
        end
        total++;
        if (acc_q.size() != 3 || acc_q[1] - acc_q[0] != 10 || acc_q[2] - acc_q[1] != 10) begin
            bad++;
            $display("FAIL t2_accept_rate: accepts=%0d, required 3 spaced 10 cycles apart", acc_q.size());
        end
        total++;
        if (ucnt !== 16'd1) begin
            bad++;
            $display("FAIL t2_ucnt: underflow_cnt=%0d, required 1", ucnt);
        end
    endtask

    task automatic test_lanes();
        do_reset();
        push(10'h001, 10'h200, 10'h0F0);
        get_word();
        get_word();
        total++;
        if (gw0 !== 10'h001 || gw1 !== 10'h200 || gw2 !== 10'h0F0) begin
            bad++;
            $display("FAIL t3_lanes: lanes=%h/%h/%h, required 001/200/0f0", gw0, gw1, gw2);
        end
        total++;
        if (gwc !== CSYM || gws !== 10'b0000000001) begin
            bad++;
            $display("FAIL t3_align: clk=%h ws=%b, required %h 0000000001", gwc, gws, CSYM);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        push(10'h2AA, 10'h2AA, 10'h2AA);
        get_word();
        get_word();
        total++;
        if (gw0 !== 10'h2AA) begin
            bad++;
            $display("FAIL t4_data: lane0=%h, required 2aa", gw0);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ucnt !== 16'(i + 1)) begin
                bad++;
                $display("FAIL t4_ucnt slot %0d: underflow_cnt=%0d, required %0d", i, ucnt, i + 1);
            end
            get_word();
            total++;
            if (gw0 !== IDLE || gw1 !== IDLE || gw2 !== IDLE) begin
                bad++;
                $display("FAIL t4_idle slot %0d: lanes=%h/%h/%h, required %h", i, gw0, gw1, gw2, IDLE);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        push(10'h0C3, 10'h0C3, 10'h0C3);
        get_word();
        get_word();
        for (int i = 0; i < 14; i++) get_word();
        total++;
        if (ucnt4 !== 4'd15) begin
            bad++;
            $display("FAIL t5_reach_max: underflow_cnt(w4)=%0d, required 15", ucnt4);
        end
        for (int i = 0; i < 6; i++) get_word();
        total++;
        if (ucnt4 !== 4'd15 || ucnt !== 16'd21) begin
            bad++;
            $display("FAIL t5_saturate: w4=%0d w16=%0d, required 15 21", ucnt4, ucnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push(10'h3E1, 10'h3E1, 10'h3E1);
        push(10'h0AB, 10'h0AB, 10'h0AB);
        get_word();
        for (int k = 0; k < 4; k++) step();
        rst_n = 1'b0;
        #1;
        total++;
        if ({data0_p, data1_p, data2_p, clk_p, word_start, s_ready} !== 6'b0 || ucnt !== 16'd0) begin
            bad++;
            $display("FAIL t6_async_clear: d/clk/ws/rdy=%b ucnt=%0d, required 000000 and 0",
                     {data0_p, data1_p, data2_p, clk_p, word_start, s_ready}, ucnt);
        end
        q0.delete(); q1.delete(); q2.delete();
        drive();
        step();
        step();
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL t6_ready_in_reset: s_ready=%b, required 0", s_ready);
        end
        rst_n = 1'b1;
        get_word();
        total++;
        if (gw0 !== IDLE || gw1 !== IDLE || gw2 !== IDLE) begin
            bad++;
            $display("FAIL t6_first_idle: lanes=%h/%h/%h, required %h", gw0, gw1, gw2, IDLE);
        end
        get_word();
        total++;
        if (gw0 !== IDLE || gw1 !== IDLE || gw2 !== IDLE) begin
            bad++;
            $display("FAIL t6_discarded: lanes=%h/%h/%h, required %h", gw0, gw1, gw2, IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_lanes();
        test_underflow();
        test_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
